// File: rtl/perlane_scrambler_multi_if.sv
// perlane_scrambler_multi_if: upper/lower data path bundle; in_prbs_mode exists only with SCRAMBLER_PRBS_EN
interface perlane_scrambler_multi_if #(
  parameter int NUM_LANES  = 4,
  parameter int LANE_WIDTH = 64
);
  logic                            in_enable;
  logic [NUM_LANES-1:0]            in_lane_mask;
  logic                            in_bypass;
  logic                            in_seed_load;
`ifdef SCRAMBLER_PRBS_EN
  logic                            in_prbs_mode;
`endif
  logic [NUM_LANES*LANE_WIDTH-1:0] in_txdata;
  logic                            in_txdata_valid;
  logic                            out_txdata_ready;
  logic [NUM_LANES*LANE_WIDTH-1:0] out_txdata;
  logic                            out_txdata_valid;
  logic                            in_txdata_ready;
  logic                            in_idle;
  logic                            out_idle;
  modport master (
`ifdef SCRAMBLER_PRBS_EN
    output in_prbs_mode,
`endif
    output in_enable, in_lane_mask, in_bypass, in_seed_load, in_txdata, in_txdata_valid,
    output in_txdata_ready, in_idle,
    input  out_txdata_ready, out_txdata, out_txdata_valid, out_idle
  );
  modport slave (
`ifdef SCRAMBLER_PRBS_EN
    input  in_prbs_mode,
`endif
    input  in_enable, in_lane_mask, in_bypass, in_seed_load, in_txdata, in_txdata_valid,
    input  in_txdata_ready, in_idle,
    output out_txdata_ready, out_txdata, out_txdata_valid, out_idle
  );
endinterface

// File: rtl/perlane_scrambler_multi.sv
// perlane_scrambler_multi: NUM_LANES x58+x39+1 self-sync TX scramblers with registered ready/valid output; SCRAMBLER_PRBS_EN adds PRBS58 mode
module perlane_scrambler_multi #(
  parameter int          NUM_LANES  = 4,
  parameter int          LANE_WIDTH = 64,
  parameter logic [57:0] SEED       = 58'h3FF_FFFF_FFFF_FFFF
) (
  input logic                     clk,
  input logic                     reset_n,
  perlane_scrambler_multi_if.slave bus
);
  localparam int W = NUM_LANES * LANE_WIDTH;
  logic         acc;
  logic         valid;
  logic [W-1:0] dout;
  logic [W-1:0] scr;
  assign bus.out_txdata_ready = bus.in_enable & (!valid | bus.in_txdata_ready);
  assign acc                  = bus.in_txdata_valid & bus.out_txdata_ready;
  assign bus.out_txdata       = dout;
  assign bus.out_txdata_valid = valid;
  assign bus.out_idle         = bus.in_idle;
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [57:0]           st;
    logic [57:0]           h;
    logic [LANE_WIDTH-1:0] d;
    logic [LANE_WIDTH-1:0] o;
    logic                  en;
`ifdef SCRAMBLER_PRBS_EN
    assign d = bus.in_prbs_mode ? '0 : bus.in_txdata[k*LANE_WIDTH +: LANE_WIDTH];
`else
    assign d = bus.in_txdata[k*LANE_WIDTH +: LANE_WIDTH];
`endif
    assign en = !bus.in_bypass & bus.in_lane_mask[k];
    // unscrambled lanes still shift their own output into h so re-enabling stays in sync
    always_comb begin
      h = bus.in_seed_load ? SEED : st;
      o = '0;
      for (int i = 0; i < LANE_WIDTH; i++) begin
        o[i] = d[i] ^ (en & (h[38] ^ h[57]));
        h    = {h[56:0], o[i]};
      end
    end
    assign scr[k*LANE_WIDTH +: LANE_WIDTH] = o;
    always_ff @(posedge clk) begin
      if (!reset_n) st <= SEED;
      else if (acc) st <= h;
      else if (bus.in_seed_load) st <= SEED;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else begin
      valid <= acc | (valid & !bus.in_txdata_ready);
      dout  <= acc ? scr : dout;
    end
  end
endmodule

// File: tb/tb_perlane_scrambler_multi.sv
// tb_perlane_scrambler_multi: directed steps with constant vectors plus a descrambler scoreboard
module tb_perlane_scrambler_multi;
  localparam int          NL = 4;
  localparam int          LW = 64;
  localparam logic [63:0] K  = 64'h0200_0040_0000_0000;
  typedef struct {
    logic [NL*LW-1:0] d;
    logic [NL-1:0]    m;
    bit               s;
  } beat_t;
  logic             clk = 1'b0;
  logic             reset_n;
  beat_t            q[$];
  logic [LW-1:0]    prev[NL];
  logic [NL*LW-1:0] held;
  bit               hist, stall, m_valid;
  int               checks, errors;
  always #5 clk = ~clk;
  perlane_scrambler_multi_if #(.NUM_LANES(NL), .LANE_WIDTH(LW)) bus ();
  perlane_scrambler_multi #(.NUM_LANES(NL), .LANE_WIDTH(LW), .SEED(58'h1)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );
  task automatic chk(input string tag, input logic [NL*LW-1:0] obs, input logic [NL*LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [NL*LW-1:0] rnd();
    logic [NL*LW-1:0] r;
    for (int i = 0; i < NL * LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  // reference descrambler: d = s ^ s[n-39] ^ s[n-58], history from the previous beat of the lane
  task automatic sb_xfer();
    beat_t          b;
    logic [LW-1:0]  ow, dw, rd;
    logic [2*LW-1:0] x;
    chk("sb_depth", q.size(), 1);
    if (q.size() == 0) return;
    b = q.pop_front();
    for (int l = 0; l < NL; l++) begin
      ow = bus.out_txdata[l*LW +: LW];
      dw = b.d[l*LW +: LW];
      if (!b.m[l]) chk($sformatf("raw_lane%0d", l), ow, dw);
      else if (b.s) begin
        x = {ow, prev[l]};
        for (int i = 0; i < LW; i++) rd[i] = x[LW+i] ^ x[LW+i-39] ^ x[LW+i-58];
        chk($sformatf("descramble_lane%0d", l), rd, dw);
      end
      prev[l] = ow;
    end
  endtask
  task automatic cycle();
    bit acc, xfer;
    #1;
    if (stall) begin
      chk("hold_valid", bus.out_txdata_valid, 1);
      chk("hold_data", bus.out_txdata, held);
    end
    chk("out_valid", bus.out_txdata_valid, m_valid);
    chk("out_ready", bus.out_txdata_ready, bus.in_enable & (!m_valid | bus.in_txdata_ready));
    chk("out_idle", bus.out_idle, bus.in_idle);
    acc  = reset_n & bus.in_enable & (!m_valid | bus.in_txdata_ready) & bus.in_txdata_valid;
    xfer = reset_n & m_valid & bus.in_txdata_ready;
    if (xfer) sb_xfer();
    stall = reset_n & m_valid & !bus.in_txdata_ready;
    held  = bus.out_txdata;
    if (!reset_n) begin
      q.delete();
      hist    = 0;
      m_valid = 0;
      stall   = 0;
    end else begin
      if (acc) q.push_back('{bus.in_txdata, bus.in_lane_mask & ~{NL{bus.in_bypass}}, hist & !bus.in_seed_load});
      hist    = acc ? 1'b1 : (bus.in_seed_load ? 1'b0 : hist);
      m_valid = acc | (m_valid & !bus.in_txdata_ready);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    checks = 0; errors = 0; hist = 0; stall = 0; m_valid = 0;
    reset_n = 0;
    bus.in_enable = 1; bus.in_lane_mask = 4'hF; bus.in_bypass = 0; bus.in_seed_load = 0;
    bus.in_txdata = '0; bus.in_txdata_valid = 0; bus.in_txdata_ready = 1; bus.in_idle = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data", bus.out_txdata, '0);
    chk("reset_valid", bus.out_txdata_valid, 0);
    chk("reset_ready", bus.out_txdata_ready, 1);
    bus.in_enable = 0;
    #1 chk("reset_ready_disabled", bus.out_txdata_ready, 0);
    bus.in_enable = 1;
    reset_n = 1;
    bus.in_txdata_valid = 1;
    cycle();
    chk("seed1_first_word", bus.out_txdata, {NL{K}});
    cycle();
    bus.in_seed_load = 1;
    cycle();
    chk("seed_load_with_beat", bus.out_txdata, {NL{K}});
    bus.in_seed_load = 0;
    bus.in_txdata_ready = 0; bus.in_txdata = rnd();
    cycle();
    bus.in_txdata = rnd();
    cycle();
    bus.in_txdata_ready = 1;
    cycle();
    for (int n = 0; n < 1400; n++) begin
      bus.in_txdata_valid = $urandom_range(0, 9) < 8;
      bus.in_txdata_ready = $urandom_range(0, 9) < 7;
      bus.in_idle = 1'($urandom_range(0, 1));
      bus.in_txdata = rnd();
      cycle();
    end
    bus.in_txdata_valid = 1; bus.in_txdata_ready = 1;
    bus.in_lane_mask = 4'b1010;
    for (int n = 0; n < 40; n++) begin bus.in_txdata = rnd(); cycle(); end
    bus.in_lane_mask = 4'b1111;
    for (int n = 0; n < 40; n++) begin bus.in_txdata = rnd(); cycle(); end
    bus.in_bypass = 1;
    for (int n = 0; n < 20; n++) begin bus.in_txdata = rnd(); cycle(); end
    bus.in_bypass = 0;
    for (int n = 0; n < 20; n++) begin bus.in_txdata = rnd(); cycle(); end
    bus.in_txdata = rnd(); bus.in_txdata_ready = 0;
    cycle();
    bus.in_enable = 0;
    cycle();
    bus.in_txdata_ready = 1;
    cycle();
    cycle();
    chk("disabled_ready", bus.out_txdata_ready, 0);
    bus.in_enable = 1; bus.in_txdata = rnd();
    cycle();
    bus.in_txdata_valid = 0;
    cycle();
    bus.in_idle = 1;
    #1 chk("idle_follow_hi", bus.out_idle, 1);
    bus.in_idle = 0;
    #1 chk("idle_follow_lo", bus.out_idle, 0);
    bus.in_txdata_valid = 1; bus.in_txdata = rnd();
    cycle();
    reset_n = 0; bus.in_txdata_valid = 0;
    cycle();
    chk("midstream_reset_data", bus.out_txdata, '0);
    reset_n = 1; bus.in_txdata_valid = 1; bus.in_txdata = '0;
    cycle();
    chk("post_reset_seed_word", bus.out_txdata, {NL{K}});
    bus.in_txdata_valid = 0;
    repeat (3) cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
